collect_symbols: RTL and testbench
==================================

COLLECT_SYMBOLS -- requirements
Module: collect_symbols

Interface
REQ-001 Parameter WORD_W, default 32, output word width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter SYM_W, default 4, input symbol bus width; SHALL equal the maximum bits per symbol.
REQ-003 Port CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port RST  input  1  reset; asynchronous, active-high.
REQ-005 Port mode_i  input  2  bits/symbol select: 0=BPSK (1 bit), 1=QPSK (2), 2=16QAM (4), 3=reserved (treated as QPSK).
REQ-006 Port valid_i  input  1  input symbol valid.
REQ-007 Port data_i  input  SYM_W  symbol; only the low bps bits are used.
REQ-008 Port ready_o  output  1  block can accept a symbol this cycle.
REQ-009 Port flush_i  input  1  single-cycle pulse that emits a partial word.
REQ-010 Port valid_o  output  1  output word valid.
REQ-011 Port ready_i  input  1  downstream accepts the word.
REQ-012 Port data_o  output  WORD_W  packed word.
REQ-013 Port nsym_o  output  clog2(WORD_W)+1  number of valid symbols in data_o.
REQ-014 Port partial_o  output  1  data_o came from a flush.

Function
REQ-015 An input transfer SHALL occur on a cycle with valid_i=1 and ready_o=1; a symbol presented while ready_o=0 SHALL NOT be consumed.
REQ-016 Output transfer: valid_o=1 and ready_i=1; data_o, nsym_o and partial_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-017 bps SHALL be latched from mode_i on the first symbol of each word; mode_i changes mid-word SHALL take effect only from the next word.
REQ-018 Symbol k of a word (k=0 first) SHALL occupy data_o[k*bps +: bps]; unfilled bits SHALL be zero.
REQ-019 A word SHALL be full after WORD_W/bps symbols (32/16/8 for WORD_W=32).
REQ-020 Datapath: assembly register and one output holding register; a full assembly word SHALL move to the holding register on the same cycle its last symbol is accepted if the holding register is empty or is being transferred out that cycle.
REQ-021 Latency: a full word SHALL present valid_o=1 on the cycle after its last symbol transfer.
REQ-022 ready_o SHALL be 0 only when the assembly register is full and the holding register holds an untransferred word; it SHALL NOT depend combinationally on valid_i.
REQ-023 Back-to-back full words at one symbol/cycle with ready_i held 1 SHALL be sustained with no ready_o deassertion.
REQ-024 flush_i with a non-empty assembly register SHALL emit that partial word (partial_o=1, nsym_o=count) through the same path; with an empty assembly register it SHALL be ignored.
REQ-025 A symbol accepted in the same cycle as flush_i SHALL be included in the flushed word; if that symbol completes the word, partial_o SHALL be 0.
REQ-026 flush_i while the holding register is occupied and not being drained SHALL be held pending and serviced when the holding register frees; ready_o SHALL be 0 while a flush is pending.
REQ-027 Controller states: EMPTY (no symbols), FILL (1..N-1 symbols), FULL_WAIT (assembly full, holding busy); transitions follow REQ-019..REQ-026.

Reset
REQ-028 RST=1 SHALL asynchronously clear valid_o=0, partial_o=0, nsym_o=0, data_o=0, symbol count=0 and pending flush, set state=EMPTY, and drive ready_o=1 after release.
REQ-029 RST asserted mid-word SHALL discard the partial word; no word SHALL be emitted for it after release.

Structure
REQ-030 Mode encodings, the bps lookup function and the state encoding SHALL live in a shared package, comm_sym_pkg.
REQ-031 One sub-module SHALL be used: sym_out_reg, a one-entry valid/ready holding register (data, nsym, partial).

Verification
REQ-032 QPSK: 16 symbols 0,1,2,3 repeating, ready_i=1 -> one word 0xE4E4E4E4, nsym_o=16, partial_o=0.
REQ-033 BPSK: 32 symbols of 1 -> 0xFFFFFFFF; 16QAM: symbols 0x1..0x8 -> 0x87654321, nsym_o=8.
REQ-034 16QAM: 3 symbols 0xA,0xB,0xC then flush_i -> 0x00000CBA, nsym_o=3, partial_o=1.
REQ-035 ready_i=0 while 2 full 16QAM words are pushed at one symbol/cycle -> ready_o drops after the 16th symbol and no symbol is lost; ready_i=1 -> both words in order.
REQ-036 mode_i switched QPSK->BPSK after symbol 5 -> current word completes as QPSK with 16 symbols; next word packs 32 BPSK symbols.
REQ-037 RST pulse after 7 QPSK symbols -> no valid_o; the next 16 symbols form a clean word.

Source files
------------

// File: rtl/comm_sym_pkg.sv
// Shared definitions for the symbol collector: modulation mode codes,
// controller state codes and the bits-per-symbol lookup.
package comm_sym_pkg;

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_16QAM = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_FILL      = 2'd1;
  localparam logic [1:0] ST_FULL_WAIT = 2'd2;

  // log2(bits per symbol); the reserved code behaves as QPSK
  function automatic logic [1:0] bps_log2(input logic [1:0] mode);
    case (mode)
      MODE_BPSK:            bps_log2 = 2'd0;
      MODE_16QAM:           bps_log2 = 2'd2;
      MODE_QPSK, MODE_RSVD: bps_log2 = 2'd1;
      default:              bps_log2 = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sym_out_reg.sv
// One-entry valid/ready holding register for packed words.
module sym_out_reg
  import comm_sym_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NSYM_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic [NSYM_W-1:0] in_nsym_i,
  input  logic              in_partial_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [NSYM_W-1:0] out_nsym_o,
  output logic              out_partial_o
);

  logic              valid_q;
  logic [WORD_W-1:0] data_q;
  logic [NSYM_W-1:0] nsym_q;
  logic              partial_q;

  // Space is available when empty or when the held word leaves this cycle
  assign in_ready_o = !valid_q || out_ready_i;

  // Load a new word whenever the slot is free; contents hold while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      nsym_q    <= '0;
      partial_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q    <= in_data_i;
        nsym_q    <= in_nsym_i;
        partial_q <= in_partial_i;
      end
    end
  end

  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_nsym_o    = nsym_q;
  assign out_partial_o = partial_q;

endmodule

// File: rtl/collect_symbols.sv
// Packs 1/2/4-bit symbols into WORD_W-bit words, LSB first, with flush
// support for partial words and a one-word output holding register.
module collect_symbols
  import comm_sym_pkg::*;
#(
  parameter  int unsigned WORD_W = 32,
  parameter  int unsigned SYM_W  = 4,
  localparam int unsigned NSYM_W = $clog2(WORD_W) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        mode_i,
  input  logic              valid_i,
  input  logic [SYM_W-1:0]  data_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WORD_W-1:0] data_o,
  output logic [NSYM_W-1:0] nsym_o,
  output logic              partial_o
);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [NSYM_W-1:0] cnt_q, cnt_d;
  logic [1:0]        lg_q, lg_d;
  logic              pend_q, pend_d;

  logic [1:0]        lg_eff;
  logic              accept;
  logic [SYM_W-1:0]  sym_mask;
  logic [NSYM_W+1:0] shamt;
  logic [WORD_W-1:0] asm_nxt;
  logic [NSYM_W-1:0] cnt_nxt;
  logic [NSYM_W-1:0] max_sym;
  logic              full;
  logic              emit;
  logic              hold_rdy;
  logic              push;

  // Registered only: never depends on valid_i
  assign ready_o = (state_q != ST_FULL_WAIT) && !pend_q;
  assign accept  = valid_i && ready_o;

  // Symbol width comes from mode_i on the first symbol, then stays latched
  assign lg_eff  = (state_q == ST_EMPTY) ? bps_log2(mode_i) : lg_q;
  assign max_sym = NSYM_W'(WORD_W >> lg_eff);

  // Keep only the low bps bits of the incoming symbol
  always_comb begin
    sym_mask = '0;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      sym_mask[i] = (i < (32'd1 << lg_eff));
    end
  end

  assign shamt   = {2'b00, cnt_q} << lg_eff;
  assign asm_nxt = accept ? (asm_q | (WORD_W'(data_i & sym_mask) << shamt)) : asm_q;
  assign cnt_nxt = accept ? (cnt_q + NSYM_W'(1)) : cnt_q;

  // The word as it will look after this cycle's symbol is what gets emitted,
  // so a symbol arriving with flush_i is included, and a word completed by
  // that symbol goes out as full rather than partial.
  assign full = (cnt_nxt == max_sym);
  assign emit = full || ((flush_i || pend_q) && (cnt_nxt != '0));
  assign push = emit && hold_rdy;

  // Controller next-state: move to holding, wait on a full word, or keep filling
  always_comb begin
    state_d = state_q;
    asm_d   = asm_nxt;
    cnt_d   = cnt_nxt;
    lg_d    = lg_eff;
    pend_d  = 1'b0;
    if (push) begin
      state_d = ST_EMPTY;
      asm_d   = '0;
      cnt_d   = '0;
    end else if (full) begin
      state_d = ST_FULL_WAIT;
    end else begin
      state_d = (cnt_nxt == '0) ? ST_EMPTY : ST_FILL;
      pend_d  = emit;
    end
  end

  // Controller and assembly state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      asm_q   <= '0;
      cnt_q   <= '0;
      lg_q    <= 2'd1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      pend_q  <= pend_d;
    end
  end

  sym_out_reg #(
    .WORD_W (WORD_W),
    .NSYM_W (NSYM_W)
  ) u_out (
    .clk_i         (CLK),
    .rst_i         (RST),
    .in_valid_i    (emit),
    .in_ready_o    (hold_rdy),
    .in_data_i     (asm_nxt),
    .in_nsym_i     (cnt_nxt),
    .in_partial_i  (!full),
    .out_valid_o   (valid_o),
    .out_ready_i   (ready_i),
    .out_data_o    (data_o),
    .out_nsym_o    (nsym_o),
    .out_partial_o (partial_o)
  );

endmodule

// File: tb/tb_collect_symbols.sv
// Bench for collect_symbols: vector table plus hand sequences for
// backpressure, pending flush, mid-word mode change and reset.
module tb_collect_symbols;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  mode_i = 2'd1;
  logic        valid_i = 1'b0;
  logic [3:0]  data_i = '0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;
  logic [5:0]  nsym_o;
  logic        partial_o;

  collect_symbols #(.WORD_W(32), .SYM_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .mode_i    (mode_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .nsym_o    (nsym_o),
    .partial_o (partial_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  n;
    logic        p;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    int          nsyms;
    logic [3:0]  base;
    logic [3:0]  step;
    logic [1:0]  flush;   // 0 none, 1 extra cycle after, 2 with last symbol
    logic [31:0] exp_d;
    logic [5:0]  exp_n;
    logic        exp_p;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic chk_rdy = 1'b0;
  int   rdy_low = 0;
  logic prev_stall = 1'b0;
  exp_t prev_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer and hold-stability watcher, sampled mid-cycle
  always @(negedge CLK) begin
    if (RST) begin
      prev_stall <= 1'b0;
    end else begin
      if (chk_rdy && !ready_o) rdy_low++;
      if (prev_stall) begin
        chk("hold_valid", {63'd0, valid_o}, 64'd1);
        chk("hold_stable", {25'd0, data_o, nsym_o, partial_o}, {25'd0, prev_word});
      end
      prev_stall <= valid_o && !ready_i;
      prev_word  <= {data_o, nsym_o, partial_o};
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {32'd0, data_o}, 64'd0);
          if (data_o == 32'd0) chk("unexpected_word_valid", {63'd0, valid_o}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_o", {32'd0, data_o}, {32'd0, e.d});
          chk("nsym_o", {58'd0, nsym_o}, {58'd0, e.n});
          chk("partial_o", {63'd0, partial_o}, {63'd0, e.p});
        end
      end
    end
  end

  // Present one symbol; called just after a rising edge, returns just after
  // the edge on which it was accepted
  task automatic send(input logic [1:0] m, input logic [3:0] d, input logic fl);
    int unsigned waitc;
    waitc = 0;
    mode_i  = m;
    data_i  = d;
    valid_i = 1'b1;
    flush_i = fl;
    @(negedge CLK);
    while (!ready_o && waitc < 200) begin
      @(negedge CLK);
      waitc++;
    end
    if (waitc >= 200) chk("send_timeout", 64'(waitc), 64'd0);
    @(posedge CLK);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge CLK);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge CLK);
      c++;
    end
    #1;
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t tab[8];

  initial begin
    tab[0] = '{2'd1, 16, 4'h0, 4'h1, 2'd0, 32'hE4E4E4E4, 6'd16, 1'b0};
    tab[1] = '{2'd0, 32, 4'hF, 4'h0, 2'd0, 32'hFFFFFFFF, 6'd32, 1'b0};
    tab[2] = '{2'd2,  8, 4'h1, 4'h1, 2'd0, 32'h87654321, 6'd8,  1'b0};
    tab[3] = '{2'd2,  3, 4'hA, 4'h1, 2'd1, 32'h00000CBA, 6'd3,  1'b1};
    tab[4] = '{2'd0,  5, 4'h1, 4'h1, 2'd1, 32'h00000015, 6'd5,  1'b1};
    tab[5] = '{2'd3, 16, 4'h2, 4'h0, 2'd0, 32'hAAAAAAAA, 6'd16, 1'b0};
    tab[6] = '{2'd2,  8, 4'h8, 4'h1, 2'd2, 32'hFEDCBA98, 6'd8,  1'b0};
    tab[7] = '{2'd1,  1, 4'h3, 4'h0, 2'd2, 32'h00000003, 6'd1,  1'b1};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("rst_data_o", {32'd0, data_o}, 64'd0);
    chk("rst_nsym_o", {58'd0, nsym_o}, 64'd0);
    chk("rst_partial_o", {63'd0, partial_o}, 64'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_ready_o", {63'd0, ready_o}, 64'd1);

    // Vector table, back to back with ready_i held high
    chk_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{tab[i].exp_d, tab[i].exp_n, tab[i].exp_p});
      for (int k = 0; k < tab[i].nsyms; k++) begin
        logic [3:0] s;
        s = tab[i].base + 4'(k) * tab[i].step;
        send(tab[i].mode, s, (tab[i].flush == 2'd2) && (k == tab[i].nsyms - 1));
      end
      if (tab[i].flush == 2'd1) pulse_flush();
    end
    drain();
    chk_rdy = 1'b0;
    chk("no_backpressure", 64'(rdy_low), 64'd0);

    // Flush with empty assembly is ignored
    pulse_flush();
    repeat (3) @(posedge CLK);
    #1;
    chk("empty_flush_no_valid", {63'd0, valid_o}, 64'd0);

    // Two 16QAM words while stalled, then a third waiting on backpressure
    ready_i = 1'b0;
    sb.push_back('{32'h76543210, 6'd8, 1'b0});
    sb.push_back('{32'hFEDCBA98, 6'd8, 1'b0});
    sb.push_back('{32'h33333333, 6'd8, 1'b0});
    for (int k = 0; k < 16; k++) send(2'd2, 4'(k), 1'b0);
    @(negedge CLK);
    chk("stall_ready_low", {63'd0, ready_o}, 64'd0);
    @(posedge CLK);
    #1;
    fork
      begin
        repeat (4) @(posedge CLK);
        #1;
        ready_i = 1'b1;
      end
      begin
        for (int k = 0; k < 8; k++) send(2'd2, 4'h3, 1'b0);
      end
    join
    drain();

    // Flush held pending while the holding register is stalled
    ready_i = 1'b0;
    sb.push_back('{32'h11111111, 6'd8, 1'b0});
    sb.push_back('{32'h00000065, 6'd2, 1'b1});
    for (int k = 0; k < 8; k++) send(2'd2, 4'h1, 1'b0);
    send(2'd2, 4'h5, 1'b0);
    send(2'd2, 4'h6, 1'b0);
    pulse_flush();
    @(negedge CLK);
    chk("pend_ready_low", {63'd0, ready_o}, 64'd0);
    @(posedge CLK);
    #1;
    ready_i = 1'b1;
    drain();

    // Mode switch mid-word: word stays QPSK, next word is BPSK
    sb.push_back('{32'hE4E4E4E4, 6'd16, 1'b0});
    sb.push_back('{32'hAAAAAAAA, 6'd32, 1'b0});
    for (int k = 0; k < 16; k++) send((k < 5) ? 2'd1 : 2'd0, 4'(k), 1'b0);
    for (int k = 0; k < 32; k++) send(2'd0, 4'(k), 1'b0);
    drain();

    // Reset mid-word with a stalled word in holding: both discarded
    ready_i = 1'b0;
    for (int k = 0; k < 16; k++) send(2'd1, 4'h3, 1'b0);
    for (int k = 0; k < 7; k++) send(2'd1, 4'h1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("async_rst_data_o", {32'd0, data_o}, 64'd0);
    chk("async_rst_nsym_o", {58'd0, nsym_o}, 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ready_i = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready_o", {63'd0, ready_o}, 64'd1);
    @(posedge CLK);
    #1;
    pulse_flush();
    repeat (3) @(posedge CLK);
    #1;
    chk("post_rst_no_valid", {63'd0, valid_o}, 64'd0);
    sb.push_back('{32'hAAAAAAAA, 6'd16, 1'b0});
    for (int k = 0; k < 16; k++) send(2'd1, 4'h2, 1'b0);
    drain();
    repeat (3) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
